stream_demux_1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer with valid/ready handshakes on every channel.
- Performs the reverse of the datapath muxing: one input stream is steered to one of two output channels.
- Routing is chosen by a select bit sampled on the first beat of each packet and held until that packet's last beat.
- Used to split result streams between two downstream consumers, e.g. alternate adder result sinks.

---
 rtl/stream_demux_1to2.sv | 160 ++++++++++++++++
 tb/tb_stream_demux_1to2.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux: the packet's first beat picks the output channel and the packet stays on it.
// Optional per-channel completed-packet counters are enabled by defining PKT_COUNT_EN.
module stream_demux_1to2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef PKT_COUNT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
`endif
);

  // state  | meaning
  // S_IDLE | waiting for a packet's first beat; in_sel routes it
  // S_BUSY | mid-packet; route_sel_q routes until the last beat
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("stream_demux_1to2: CNT_W must be at least 1");
  end

  state_t           state_q, state_d;
  logic             route_sel_q, route_sel_d;
  logic             out0_valid_q, out0_valid_d;
  logic             out0_last_q, out0_last_d;
  logic [WIDTH-1:0] out0_data_q, out0_data_d;
  logic             out1_valid_q, out1_valid_d;
  logic             out1_last_q, out1_last_d;
  logic [WIDTH-1:0] out1_data_q, out1_data_d;

  logic eff_sel, free0, free1, accept, acc0, acc1;

  // The unselected channel never gates in_ready, so a stalled consumer only blocks its own traffic.
  always_comb begin
    eff_sel  = (state_q == S_IDLE) ? in_sel : route_sel_q;
    free0    = !out0_valid_q || out0_ready;
    free1    = !out1_valid_q || out1_ready;
    in_ready = eff_sel ? free1 : free0;
    accept   = in_valid && in_ready;
    acc0     = accept && !eff_sel;
    acc1     = accept && eff_sel;
  end

  always_comb begin
    state_d     = state_q;
    route_sel_d = route_sel_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !in_last) begin
          state_d     = S_BUSY;
          route_sel_d = in_sel;
        end
      end
      S_BUSY: begin
        if (accept && in_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out0_valid_d = out0_valid_q;
    out0_last_d  = out0_last_q;
    out0_data_d  = out0_data_q;
    if (acc0) begin
      out0_valid_d = 1'b1;
      out0_last_d  = in_last;
      out0_data_d  = in_data;
    end else if (out0_ready) begin
      out0_valid_d = 1'b0;
    end
  end

  always_comb begin
    out1_valid_d = out1_valid_q;
    out1_last_d  = out1_last_q;
    out1_data_d  = out1_data_q;
    if (acc1) begin
      out1_valid_d = 1'b1;
      out1_last_d  = in_last;
      out1_data_d  = in_data;
    end else if (out1_ready) begin
      out1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      route_sel_q  <= 1'b0;
      out0_valid_q <= 1'b0;
      out0_last_q  <= 1'b0;
      out0_data_q  <= '0;
      out1_valid_q <= 1'b0;
      out1_last_q  <= 1'b0;
      out1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      route_sel_q  <= route_sel_d;
      out0_valid_q <= out0_valid_d;
      out0_last_q  <= out0_last_d;
      out0_data_q  <= out0_data_d;
      out1_valid_q <= out1_valid_d;
      out1_last_q  <= out1_last_d;
      out1_data_q  <= out1_data_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out0_last  = out0_last_q;
  assign out0_data  = out0_data_q;
  assign out1_valid = out1_valid_q;
  assign out1_last  = out1_last_q;
  assign out1_data  = out1_data_q;

`ifdef PKT_COUNT_EN
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (acc0 && in_last) pkt_cnt0_d = pkt_cnt0_q + 1'b1;
    if (acc1 && in_last) pkt_cnt1_d = pkt_cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed test-plan scenarios then random traffic, all checked against a packet-level model.
// Counter checks are active when PKT_COUNT_EN is defined.
module tb_stream_demux_1to2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_valid;
  logic             out1_ready;
`ifdef PKT_COUNT_EN
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;
`endif

  stream_demux_1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef PKT_COUNT_EN
    ,
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level reference: which channel the current packet is locked to, and what each one-deep
  // output slot holds from the consumer's point of view.
  bit             m_in_pkt;
  bit             m_lock;
  bit             m_full [2];
  logic [WIDTH:0] m_beat [2];
  int             m_cnt  [2];
  int             n_out1_seen;

  task automatic model_reset();
    m_in_pkt = 0;
    m_lock   = 0;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0;
      m_beat[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic l,
                      input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    bit ch;
    bit exp_rdy;
    bit acc;
    bit rdy [2];
    @(negedge clk);
    rst = r; in_valid = v; in_sel = s; in_last = l; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    rdy[0] = r0; rdy[1] = r1;
    ch      = m_in_pkt ? m_lock : s;
    exp_rdy = !m_full[ch] || rdy[ch];
    check("in_ready", in_ready, exp_rdy);
    check("out0_valid", out0_valid, m_full[0]);
    check("out1_valid", out1_valid, m_full[1]);
    if (m_full[0]) check("out0_beat", {out0_last, out0_data}, m_beat[0]);
    if (m_full[1]) check("out1_beat", {out1_last, out1_data}, m_beat[1]);
`ifdef PKT_COUNT_EN
    check("pkt_cnt0", pkt_cnt0, m_cnt[0] % (1 << CNT_W));
    check("pkt_cnt1", pkt_cnt1, m_cnt[1] % (1 << CNT_W));
`endif
    if (out1_valid) n_out1_seen++;
    acc = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) if (m_full[i] && rdy[i]) m_full[i] = 0;
      if (acc) begin
        m_full[ch] = 1;
        m_beat[ch] = {l, d};
        if (l) begin
          m_in_pkt = 0;
          m_cnt[ch]++;
        end else if (!m_in_pkt) begin
          m_in_pkt = 1;
          m_lock   = s;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_sel = 0; in_last = 0; in_data = '0;
    out0_ready = 0; out1_ready = 0;
    model_reset();
    n_out1_seen = 0;

    // Reset state
    step(1, 0, 0, 0, 8'h00, 0, 0);
    step(1, 1, 1, 1, 8'hFF, 1, 1);
    step(0, 0, 0, 0, 8'h00, 0, 0);
    check("rst_out0_data", {out0_last, out0_data}, 9'h000);
    check("rst_out1_data", {out1_last, out1_data}, 9'h000);

    // Single beat to out1
    step(0, 1, 1, 1, 8'hA5, 1, 1);
    step(0, 0, 0, 0, 8'h00, 0, 0);
    check("single_out1", {out1_valid, out1_last, out1_data}, {2'b11, 8'hA5});
    check("single_out0_valid", out0_valid, 1'b0);
    step(0, 0, 0, 0, 8'h00, 1, 1);

    // Packet lock: in_sel toggles after the first beat
    n_out1_seen = 0;
    step(0, 1, 0, 0, 8'h11, 1, 1);
    step(0, 1, 1, 0, 8'h22, 1, 1);
    step(0, 1, 1, 1, 8'h33, 1, 1);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check("lock_last_beat", {out0_valid, out0_last, out0_data}, {2'b11, 8'h33});
    check("lock_out1_never", n_out1_seen, 0);
    step(0, 0, 0, 0, 8'h00, 1, 1);

    // Backpressure on out0, out1 still usable
    step(0, 1, 0, 1, 8'h5C, 0, 0);
    step(0, 1, 0, 1, 8'h77, 0, 0);
    check("bp_in_ready_sel0", in_ready, 1'b0);
    check("bp_out0_hold", out0_data, 8'h5C);
    step(0, 1, 1, 1, 8'h66, 0, 1);
    check("bp_in_ready_sel1", in_ready, 1'b1);
    step(0, 0, 0, 0, 8'h00, 0, 0);
    check("bp_out1", {out1_valid, out1_data}, {1'b1, 8'h66});
    check("bp_out0_still", out0_data, 8'h5C);
    step(0, 0, 0, 0, 8'h00, 1, 1);

    // Full throughput: 8 back-to-back beats
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, (i == 7), 8'(i), 1, 0);
      check("tput_in_ready", in_ready, 1'b1);
    end
    step(0, 0, 0, 0, 8'h00, 1, 0);
    check("tput_last", {out0_valid, out0_last, out0_data}, {2'b11, 8'h07});
    step(0, 0, 0, 0, 8'h00, 1, 1);

    // Reset mid-packet on a 4-beat packet to out1
    step(0, 1, 1, 0, 8'hB1, 1, 1);
    step(0, 1, 1, 0, 8'hB2, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 1, 8'hC0, 1, 1);
    check("mid_rst_out1_valid", out1_valid, 1'b0);
    step(0, 0, 0, 0, 8'h00, 0, 0);
    check("mid_rst_out0", {out0_valid, out0_data}, {1'b1, 8'hC0});
    step(0, 0, 0, 0, 8'h00, 1, 1);

    // Packet counters: 3 packets to out0, 2 to out1, then 5 more to out0 wrap CNT_W=2
    step(1, 0, 0, 0, 8'h00, 1, 1);
    for (int p = 0; p < 5; p++) begin
      step(0, 1, (p >= 3), 0, 8'(p), 1, 1);
      step(0, 1, !(p >= 3), 1, 8'(p + 8'h40), 1, 1);
    end
    step(0, 0, 0, 0, 8'h00, 1, 1);
`ifdef PKT_COUNT_EN
    check("cnt0_three", pkt_cnt0, 2'd3);
    check("cnt1_two", pkt_cnt1, 2'd2);
`endif
    step(1, 0, 0, 0, 8'h00, 1, 1);
    for (int p = 0; p < 5; p++) step(0, 1, 0, 1, 8'(p), 1, 1);
    step(0, 0, 0, 0, 8'h00, 1, 1);
`ifdef PKT_COUNT_EN
    check("cnt0_wrap", pkt_cnt0, 2'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
